rv32i_multicycle_cpu: RTL and testbench
=======================================

Name: rv32i_multicycle_cpu

Overview:
- Multicycle, unpipelined RV32I integer core that fetches and executes one instruction at a time.
- Uses a single shared instruction/data memory port with a level enable/ready handshake.
- Sits between the system RAM model/bus and nothing else: it is the only bus master.
- Register file and program counter are internal and hierarchically visible as `registers[0:31]` and `program_counter`.

Parameters:
- RESET_PC, 32'h0000_0000, program counter value loaded on reset.
- RESET_SP, 32'h0000_FFFF, value loaded into x2 (stack pointer) on reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- memory_address  output  32  byte address of the current access.
- memory_data_in  input  32  read data, little-endian, right-aligned (byte in [7:0], half in [15:0]).
- memory_data_out  output  32  write data, right-aligned.
- memory_data_size  output  2  0=byte, 1=halfword, 2=word; 3 is never driven.
- memory_enable  output  1  request active.
- memory_operation  output  1  0=read, 1=write.
- memory_ready  input  1  memory has completed the request (read data valid / write done).

Behaviour:
- Reset (reset_n low, asynchronous):
  - program_counter=RESET_PC; x2=RESET_SP; all other registers 0.
  - memory_enable=0, memory_operation=0, memory_address=0, memory_data_out=0, memory_data_size=0.
  - State=FETCH.
  - Reset asserted mid-transaction aborts it immediately, with enable dropping asynchronously.
- All memory outputs are registered.
- Handshake rules:
  - A request is issued only when memory_ready is low. Address, size, operation and data are set in the same edge as enable rises and stay stable while enable=1.
  - The first rising edge with enable=1 and ready=1 completes the request: read data is captured from memory_data_in and enable goes to 0 on that edge.
  - Until the next request, the CPU waits for ready to return low.
  - Arbitrary wait states are allowed.
- Addresses are byte addresses. Misaligned accesses are passed through unchanged; there are no alignment traps.
- States:
  - FETCH: word read at program_counter. On completion, latch the instruction and go to EXECUTE.
  - EXECUTE (1 cycle): decode and ALU.
    - Non-memory instruction: write rd, update PC, go to FETCH.
    - Load/store: go to MEMORY.
  - MEMORY: issue the data access. On completion, a load writes rd (sign- or zero-extended); then PC+=4 and go to FETCH.
  - HALT: terminal. No further requests; PC holds the address of the halting instruction.
- Instruction support:
  - Full RV32I: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Loads LB/LH/LW/LBU/LHU; stores SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Semantics:
  - All arithmetic is 32-bit with wrap-around.
  - Shift amount is the low 5 bits.
  - JAL/JALR write PC+4 to rd. JALR target = (rs1+imm) with bit 0 cleared, using the rs1 value read before the write.
  - Branch target = PC+imm; not taken → PC+4.
- x0 always reads 0; writes to x0 are discarded.
- FENCE executes as a NOP.
- ECALL, EBREAK and any unrecognised opcode enter HALT.
- Minimum instruction latency:
  - ALU/branch/jump: fetch (≥2 cycles) + 1 execute cycle.
  - Load/store: additionally ≥2 cycles for the data access.

Test Plan:
- Reset then program `ADDI x1,x0,5; ADDI x1,x1,-7` at 0 → word fetches at 0 and 4 (size 2, op 0); x1=0xFFFF_FFFE; x2=0xFFFF after reset.
- `LUI x3,0x12345; SW x3,8(x0); LB x4,9(x0); LBU x5,9(x0)` → write of 0x12345000 at address 8 (size 2, op 1); read of address 9 with size 0; x4=0x0000_0050, x5=0x50. Also store 0x80 via SB and verify LB yields 0xFFFF_FF80 while LHU of 0x8080 yields 0x0000_8080.
- `BEQ x0,x0,+8` at PC 0 → next fetch at 8. `BNE x0,x0,+8` → next fetch at 4. `BLT` with -1 vs 1 is taken; `BLTU` with the same operands is not taken.
- `JAL x1,+16` at 0x10 → x1=0x14, fetch at 0x20. `JALR x0,3(x1)` → fetch at 0x16 (bit 0 cleared).
- Memory holding ready low for 5 cycles during fetch → memory_enable stays 1 with a stable address; the instruction executes once ready rises. `ADDI x0,x0,1` leaves x0=0.
- Assert reset_n low while memory_enable=1 → enable drops immediately; after release, the first fetch is at RESET_PC. An ECALL enters HALT and no further memory_enable pulses occur.

Source files
------------

// File: rtl/rv32i_multicycle_cpu.sv
`timescale 1ns/1ps
// rv32i_multicycle_cpu
// Multicycle, unpipelined RV32I core. It runs one instruction at a time through
// FETCH -> EXECUTE -> (MEMORY) -> FETCH. It has a single shared instruction/data port
// with a level enable/ready handshake, and it is the only master on that port.
//
// Ports:
//   clock             rising-edge system clock
//   reset_n           asynchronous active-low reset
//   memory_address    byte address of the current access (registered)
//   memory_data_in    read data, little-endian, right-aligned
//   memory_data_out   write data, right-aligned (registered)
//   memory_data_size  0=byte, 1=half, 2=word (registered)
//   memory_enable     request active (registered)
//   memory_operation  0=read, 1=write (registered)
//   memory_ready      memory has completed the request
module rv32i_multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] RESET_SP = 32'h0000_FFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] memory_address,
    input  logic [31:0] memory_data_in,
    output logic [31:0] memory_data_out,
    output logic [1:0]  memory_data_size,
    output logic        memory_enable,
    output logic        memory_operation,
    input  logic        memory_ready
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [1:0] {S_FETCH, S_EXECUTE, S_MEMORY, S_HALT} state_t;

    state_t      state_q;
    logic [31:0] registers [0:31];
    logic [31:0] program_counter;
    logic [31:0] instr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_size_q;
    logic        mem_en_q;
    logic        mem_op_q;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [2:0]  funct3_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] pc_plus4_s;
    logic        is_store_s;
    logic [31:0] mem_ea_s;
    logic [31:0] store_data_s;
    logic [31:0] load_data_s;
    logic        ex_wb_en_s;
    logic [31:0] ex_wb_data_s;
    logic [31:0] ex_next_pc_s;
    logic        ex_mem_s;
    logic        ex_halt_s;
    logic        taken_s;

    assign memory_address   = mem_addr_q;
    assign memory_data_out  = mem_wdata_q;
    assign memory_data_size = mem_size_q;
    assign memory_enable    = mem_en_q;
    assign memory_operation = mem_op_q;

    function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic alt,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] sra_v;
        // kept apart from the ternary so the arithmetic shift stays signed
        sra_v = $signed(a) >>> b[4:0];
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'h0, ($signed(a) < $signed(b))};
            3'b011:  r = {31'h0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? sra_v : (a >> b[4:0]);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Field extraction, operand read, immediates and memory-side data shaping
    always_comb begin
        opcode_s   = instr_q[6:0];
        rd_s       = instr_q[11:7];
        funct3_s   = instr_q[14:12];
        rs1_s      = instr_q[19:15];
        rs2_s      = instr_q[24:20];
        rs1_v_s    = (rs1_s == 5'd0) ? 32'h0 : registers[rs1_s];
        rs2_v_s    = (rs2_s == 5'd0) ? 32'h0 : registers[rs2_s];
        imm_i_s    = {{20{instr_q[31]}}, instr_q[31:20]};
        imm_s_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        imm_b_s    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
        imm_u_s    = {instr_q[31:12], 12'h000};
        imm_j_s    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
        pc_plus4_s = program_counter + 32'd4;
        is_store_s = (opcode_s == OP_STORE);
        mem_ea_s   = rs1_v_s + (is_store_s ? imm_s_s : imm_i_s);
        case (funct3_s[1:0])
            2'b00:   store_data_s = {24'h0, rs2_v_s[7:0]};
            2'b01:   store_data_s = {16'h0, rs2_v_s[15:0]};
            default: store_data_s = rs2_v_s;
        endcase
        case (funct3_s)
            3'b000:  load_data_s = {{24{memory_data_in[7]}}, memory_data_in[7:0]};
            3'b001:  load_data_s = {{16{memory_data_in[15]}}, memory_data_in[15:0]};
            3'b100:  load_data_s = {24'h0, memory_data_in[7:0]};
            3'b101:  load_data_s = {16'h0, memory_data_in[15:0]};
            default: load_data_s = memory_data_in;
        endcase
    end

    // Execute-stage decision: writeback value, next PC, memory or halt
    always_comb begin
        ex_wb_en_s   = 1'b0;
        ex_wb_data_s = 32'h0;
        ex_next_pc_s = pc_plus4_s;
        ex_mem_s     = 1'b0;
        ex_halt_s    = 1'b0;
        taken_s      = 1'b0;
        case (opcode_s)
            OP_LUI: begin
                ex_wb_en_s   = 1'b1;
                ex_wb_data_s = imm_u_s;
            end
            OP_AUIPC: begin
                ex_wb_en_s   = 1'b1;
                ex_wb_data_s = program_counter + imm_u_s;
            end
            OP_JAL: begin
                ex_wb_en_s   = 1'b1;
                ex_wb_data_s = pc_plus4_s;
                ex_next_pc_s = program_counter + imm_j_s;
            end
            OP_JALR: begin
                // target uses rs1 as read before this instruction's own writeback
                ex_wb_en_s   = 1'b1;
                ex_wb_data_s = pc_plus4_s;
                ex_next_pc_s = (rs1_v_s + imm_i_s) & 32'hFFFF_FFFE;
            end
            OP_BRANCH: begin
                case (funct3_s)
                    3'b000:  taken_s = (rs1_v_s == rs2_v_s);
                    3'b001:  taken_s = (rs1_v_s != rs2_v_s);
                    3'b100:  taken_s = ($signed(rs1_v_s) < $signed(rs2_v_s));
                    3'b101:  taken_s = !($signed(rs1_v_s) < $signed(rs2_v_s));
                    3'b110:  taken_s = (rs1_v_s < rs2_v_s);
                    3'b111:  taken_s = !(rs1_v_s < rs2_v_s);
                    default: ex_halt_s = 1'b1;
                endcase
                ex_next_pc_s = taken_s ? (program_counter + imm_b_s) : pc_plus4_s;
            end
            OP_LOAD: begin
                case (funct3_s)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ex_mem_s = 1'b1;
                    default: ex_halt_s = 1'b1;
                endcase
            end
            OP_STORE: begin
                case (funct3_s)
                    3'b000, 3'b001, 3'b010: ex_mem_s = 1'b1;
                    default: ex_halt_s = 1'b1;
                endcase
            end
            OP_IMM: begin
                ex_wb_en_s   = 1'b1;
                ex_wb_data_s = alu_calc(funct3_s, (funct3_s == 3'b101) && instr_q[30], rs1_v_s, imm_i_s);
            end
            OP_REG: begin
                ex_wb_en_s   = 1'b1;
                ex_wb_data_s = alu_calc(funct3_s, instr_q[30], rs1_v_s, rs2_v_s);
            end
            OP_FENCE: begin
                ex_wb_en_s = 1'b0;
            end
            default: ex_halt_s = 1'b1;  // SYSTEM (ECALL/EBREAK) and unknown opcodes
        endcase
    end

    // Main FSM: bus handshake, register file and PC update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_FETCH;
            program_counter <= RESET_PC;
            instr_q         <= 32'h0;
            mem_addr_q      <= 32'h0;
            mem_wdata_q     <= 32'h0;
            mem_size_q      <= 2'd0;
            mem_en_q        <= 1'b0;
            mem_op_q        <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                registers[i[4:0]] <= (i == 2) ? RESET_SP : 32'h0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_en_q) begin
                        if (memory_ready) begin
                            instr_q  <= memory_data_in;
                            mem_en_q <= 1'b0;
                            state_q  <= S_EXECUTE;
                        end
                    end else if (!memory_ready) begin
                        // a new request waits until the previous one's ready has dropped
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= program_counter;
                        mem_size_q  <= 2'd2;
                        mem_op_q    <= 1'b0;
                        mem_wdata_q <= 32'h0;
                    end
                end
                S_EXECUTE: begin
                    if (ex_halt_s) begin
                        state_q <= S_HALT;
                    end else if (ex_mem_s) begin
                        state_q <= S_MEMORY;
                    end else begin
                        if (ex_wb_en_s && (rd_s != 5'd0)) begin
                            registers[rd_s] <= ex_wb_data_s;
                        end
                        program_counter <= ex_next_pc_s;
                        state_q         <= S_FETCH;
                    end
                end
                S_MEMORY: begin
                    if (mem_en_q) begin
                        if (memory_ready) begin
                            mem_en_q <= 1'b0;
                            if (!is_store_s && (rd_s != 5'd0)) begin
                                registers[rd_s] <= load_data_s;
                            end
                            program_counter <= pc_plus4_s;
                            state_q         <= S_FETCH;
                        end
                    end else if (!memory_ready) begin
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= mem_ea_s;
                        mem_size_q  <= funct3_s[1:0];
                        mem_op_q    <= is_store_s;
                        mem_wdata_q <= is_store_s ? store_data_s : 32'h0;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_cpu.sv
`timescale 1ns/1ps
// Self-checking bench for rv32i_multicycle_cpu: a byte-array memory responder with
// configurable wait states, and a transaction scoreboard fed by the directed test steps.
module tb_rv32i_multicycle_cpu;

    logic        clock;
    logic        reset_n;
    logic [31:0] memory_address;
    logic [31:0] memory_data_in;
    logic [31:0] memory_data_out;
    logic [1:0]  memory_data_size;
    logic        memory_enable;
    logic        memory_operation;
    logic        memory_ready;

    typedef logic [66:0] txn_t;  // {address, size, operation, write data or 0}

    logic [7:0] mem [0:1023];
    txn_t       exp_q[$];
    int         n_assert;
    int         n_fail;
    int         wait_states;

    rv32i_multicycle_cpu #(.RESET_PC(32'h0000_0000), .RESET_SP(32'h0000_FFFF)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .memory_address   (memory_address),
        .memory_data_in   (memory_data_in),
        .memory_data_out  (memory_data_out),
        .memory_data_size (memory_data_size),
        .memory_enable    (memory_enable),
        .memory_operation (memory_operation),
        .memory_ready     (memory_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] w;
        w = {mem[(a + 32'd3) & 32'h3FF], mem[(a + 32'd2) & 32'h3FF], mem[(a + 32'd1) & 32'h3FF], mem[a & 32'h3FF]};
        case (sz)
            2'd0:    return {24'h0, w[7:0]};
            2'd1:    return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        mem[a & 32'h3FF]            = w[7:0];
        mem[(a + 32'd1) & 32'h3FF]  = w[15:8];
        mem[(a + 32'd2) & 32'h3FF]  = w[23:16];
        mem[(a + 32'd3) & 32'h3FF]  = w[31:24];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        exp_q.delete();
    endtask

    task automatic exp_txn(input logic [31:0] a, input logic [1:0] sz, input logic op, input logic [31:0] d);
        exp_q.push_back({a, sz, op, d});
    endtask

    task automatic exp_fetch(input logic [31:0] a);
        exp_txn(a, 2'd2, 1'b0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder, acting on falling edges so it never races the DUT's rising edge.
    initial begin : responder
        txn_t cur;
        txn_t want;
        txn_t pend_req;
        bit   pend;
        int   wait_cnt;
        memory_ready   = 1'b0;
        memory_data_in = 32'h0;
        pend           = 1'b0;
        wait_cnt       = 0;
        forever begin
            @(negedge clock);
            cur = {memory_address, memory_data_size, memory_operation, memory_data_out};
            if (!memory_enable) begin
                memory_ready = 1'b0;
                wait_cnt     = 0;
                pend         = 1'b0;
            end else if (!memory_ready) begin
                if (pend) begin
                    n_assert++;
                    assert (cur === pend_req) else begin
                        n_fail++;
                        $error("FAIL req_stable: observed %h expected %h", cur, pend_req);
                    end
                end else begin
                    pend     = 1'b1;
                    pend_req = cur;
                end
                if (wait_cnt >= wait_states) begin
                    if (memory_operation) begin
                        mem[memory_address & 32'h3FF] = memory_data_out[7:0];
                        if (memory_data_size != 2'd0) mem[(memory_address + 32'd1) & 32'h3FF] = memory_data_out[15:8];
                        if (memory_data_size == 2'd2) begin
                            mem[(memory_address + 32'd2) & 32'h3FF] = memory_data_out[23:16];
                            mem[(memory_address + 32'd3) & 32'h3FF] = memory_data_out[31:24];
                        end
                        memory_data_in = 32'h0;
                    end else begin
                        cur[31:0]      = 32'h0;
                        memory_data_in = mem_read(memory_address, memory_data_size);
                    end
                    memory_ready = 1'b1;
                    n_assert++;
                    assert (exp_q.size() > 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_txn: observed %h expected none", cur);
                    end
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        n_assert++;
                        assert (cur === want) else begin
                            n_fail++;
                            $error("FAIL txn: observed %h expected %h", cur, want);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_enable", {31'h0, memory_enable}, 32'h0);
        chk("rst_op", {31'h0, memory_operation}, 32'h0);
        chk("rst_addr", memory_address, 32'h0);
        chk("rst_dout", memory_data_out, 32'h0);
        chk("rst_size", {30'h0, memory_data_size}, 32'h0);
        chk("rst_pc", dut.program_counter, 32'h0);
        chk("rst_x2", dut.registers[2], 32'h0000_FFFF);
        chk("rst_x1", dut.registers[1], 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic run(input int max_cycles);
        for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) @(negedge clock);
        repeat (30) @(negedge clock);  // any request after halt shows up as unexpected
        chk("scoreboard_drained", exp_q.size(), 32'h0);
    endtask

    task automatic load_prog1();
        clear_mem();
        put_word(32'h0, enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
        put_word(32'h4, enc_i(-32'sd7, 5'd1, 3'b000, 5'd1, 7'b0010011));
        put_word(32'h8, enc_i(32'd1, 5'd0, 3'b000, 5'd0, 7'b0010011));
        put_word(32'hC, 32'h0000_0073);
        exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8); exp_fetch(32'hC);
    endtask

    task automatic check_prog1();
        chk("p1_x1", dut.registers[1], 32'hFFFF_FFFE);
        chk("p1_x0", dut.registers[0], 32'h0);
        chk("p1_x2", dut.registers[2], 32'h0000_FFFF);
        chk("p1_pc", dut.program_counter, 32'hC);
    endtask

    initial begin : main
        reset_n     = 1'b0;
        n_assert    = 0;
        n_fail      = 0;
        wait_states = 0;

        // 1: ALU immediates, negative result, write to x0
        load_prog1();
        do_reset();
        run(400);
        check_prog1();

        // 2: stores and loads with sign/zero extension
        clear_mem();
        put_word(32'h00, enc_j(32'h40, 5'd0));
        put_word(32'h40, {20'h12345, 5'd3, 7'b0110111});
        put_word(32'h44, enc_s(32'd8, 5'd3, 5'd0, 3'b010));
        put_word(32'h48, enc_i(32'd9, 5'd0, 3'b000, 5'd4, 7'b0000011));
        put_word(32'h4C, enc_i(32'd9, 5'd0, 3'b100, 5'd5, 7'b0000011));
        put_word(32'h50, enc_i(32'h80, 5'd0, 3'b000, 5'd6, 7'b0010011));
        put_word(32'h54, enc_s(32'd12, 5'd6, 5'd0, 3'b000));
        put_word(32'h58, enc_s(32'd13, 5'd6, 5'd0, 3'b000));
        put_word(32'h5C, enc_i(32'd12, 5'd0, 3'b000, 5'd7, 7'b0000011));
        put_word(32'h60, enc_i(32'd12, 5'd0, 3'b101, 5'd8, 7'b0000011));
        put_word(32'h64, enc_i(32'd12, 5'd0, 3'b001, 5'd9, 7'b0000011));
        put_word(32'h68, enc_i(32'd8, 5'd0, 3'b010, 5'd10, 7'b0000011));
        put_word(32'h6C, 32'h0000_0073);
        exp_fetch(32'h00); exp_fetch(32'h40); exp_fetch(32'h44);
        exp_txn(32'd8, 2'd2, 1'b1, 32'h1234_5000);
        exp_fetch(32'h48); exp_txn(32'd9, 2'd0, 1'b0, 32'h0);
        exp_fetch(32'h4C); exp_txn(32'd9, 2'd0, 1'b0, 32'h0);
        exp_fetch(32'h50); exp_fetch(32'h54); exp_txn(32'd12, 2'd0, 1'b1, 32'h80);
        exp_fetch(32'h58); exp_txn(32'd13, 2'd0, 1'b1, 32'h80);
        exp_fetch(32'h5C); exp_txn(32'd12, 2'd0, 1'b0, 32'h0);
        exp_fetch(32'h60); exp_txn(32'd12, 2'd1, 1'b0, 32'h0);
        exp_fetch(32'h64); exp_txn(32'd12, 2'd1, 1'b0, 32'h0);
        exp_fetch(32'h68); exp_txn(32'd8, 2'd2, 1'b0, 32'h0);
        exp_fetch(32'h6C);
        do_reset();
        run(800);
        chk("ls_x3", dut.registers[3], 32'h1234_5000);
        chk("ls_lb", dut.registers[4], 32'h0000_0050);
        chk("ls_lbu", dut.registers[5], 32'h0000_0050);
        chk("ls_lb_neg", dut.registers[7], 32'hFFFF_FF80);
        chk("ls_lhu", dut.registers[8], 32'h0000_8080);
        chk("ls_lh", dut.registers[9], 32'hFFFF_8080);
        chk("ls_lw", dut.registers[10], 32'h1234_5000);
        chk("ls_pc", dut.program_counter, 32'h6C);

        // 3: branches taken / not taken, signed vs unsigned compare
        clear_mem();
        put_word(32'd0,  enc_b(32'd8, 5'd0, 5'd0, 3'b000));
        put_word(32'd4,  enc_i(32'd1, 5'd0, 3'b000, 5'd11, 7'b0010011));
        put_word(32'd8,  enc_b(32'd8, 5'd0, 5'd0, 3'b001));
        put_word(32'd12, enc_i(32'hFFF, 5'd0, 3'b000, 5'd12, 7'b0010011));
        put_word(32'd16, enc_i(32'd1, 5'd0, 3'b000, 5'd13, 7'b0010011));
        put_word(32'd20, enc_b(32'd8, 5'd13, 5'd12, 3'b100));
        put_word(32'd24, enc_i(32'd2, 5'd0, 3'b000, 5'd11, 7'b0010011));
        put_word(32'd28, enc_b(32'd8, 5'd13, 5'd12, 3'b110));
        put_word(32'd32, 32'h0000_0073);
        exp_fetch(32'd0); exp_fetch(32'd8); exp_fetch(32'd12); exp_fetch(32'd16);
        exp_fetch(32'd20); exp_fetch(32'd28); exp_fetch(32'd32);
        do_reset();
        run(400);
        chk("br_skipped", dut.registers[11], 32'h0);
        chk("br_pc", dut.program_counter, 32'd32);

        // 4: JAL link value and JALR with bit 0 cleared (misaligned fetch passes through)
        clear_mem();
        put_word(32'h00, enc_j(32'h10, 5'd0));
        put_word(32'h10, enc_j(32'd16, 5'd1));
        put_word(32'h20, enc_i(32'd3, 5'd1, 3'b000, 5'd0, 7'b1100111));
        put_word(32'h16, enc_i(32'd7, 5'd0, 3'b000, 5'd6, 7'b0010011));
        put_word(32'h1A, 32'h0000_0073);
        exp_fetch(32'h00); exp_fetch(32'h10); exp_fetch(32'h20); exp_fetch(32'h16); exp_fetch(32'h1A);
        do_reset();
        run(400);
        chk("jal_link", dut.registers[1], 32'h14);
        chk("jalr_target_insn", dut.registers[6], 32'd7);
        chk("jalr_pc", dut.program_counter, 32'h1A);

        // 5: register ALU ops with 5 wait states on every access
        wait_states = 5;
        clear_mem();
        put_word(32'd0,  enc_i(32'hFF0, 5'd0, 3'b000, 5'd1, 7'b0010011));
        put_word(32'd4,  enc_i(32'd3, 5'd0, 3'b000, 5'd2, 7'b0010011));
        put_word(32'd8,  enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd3));
        put_word(32'd12, enc_r(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd4));
        put_word(32'd16, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd5));
        put_word(32'd20, enc_r(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd6));
        put_word(32'd24, enc_r(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd7));
        put_word(32'd28, enc_i(32'h00F, 5'd1, 3'b100, 5'd8, 7'b0010011));
        put_word(32'd32, enc_i(32'd4, 5'd2, 3'b001, 5'd9, 7'b0010011));
        put_word(32'd36, {20'h00001, 5'd10, 7'b0010111});
        put_word(32'd40, 32'h0000_0073);
        for (int a = 0; a <= 40; a += 4) exp_fetch(a);
        do_reset();
        run(1500);
        chk("alu_sra", dut.registers[3], 32'hFFFF_FFFE);
        chk("alu_srl", dut.registers[4], 32'h1FFF_FFFE);
        chk("alu_sub", dut.registers[5], 32'd19);
        chk("alu_sltu", dut.registers[6], 32'd1);
        chk("alu_slt", dut.registers[7], 32'd1);
        chk("alu_xori", dut.registers[8], 32'hFFFF_FFFF);
        chk("alu_slli", dut.registers[9], 32'h30);
        chk("alu_auipc", dut.registers[10], 32'h1024);
        chk("alu_pc", dut.program_counter, 32'd40);

        // 6: reset during an outstanding fetch, then a clean restart at RESET_PC
        wait_states = 20;
        load_prog1();
        do_reset();
        for (int k = 0; k < 50 && !memory_enable; k++) @(negedge clock);
        chk("abort_enable_seen", {31'h0, memory_enable}, 32'h1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_enable_drop", {31'h0, memory_enable}, 32'h0);
        wait_states = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run(400);
        check_prog1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
